// File: rtl/dmem_rr_arbiter_if.sv
// Bundle between the core MEM stages, the round-robin arbiter and the data-memory port.
// slave  : arbiter view (takes core commands and read data, drives grants and memory command)
// master : environment view (cores plus data memory)
interface dmem_rr_arbiter_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    Req;
    logic [NUM_CORES-1:0]    Write;
    logic [NUM_CORES-1:0]    Lock;
    logic [32*NUM_CORES-1:0] Addr;
    logic [32*NUM_CORES-1:0] WData;
    logic [NUM_CORES-1:0]    Grant;
    logic [NUM_CORES-1:0]    RdValid;
    logic [31:0]             RdData;
    logic                    LockErr;
    logic [31:0]             Mem_Address;
    logic [31:0]             Mem_WriteData;
    logic                    Mem_MemWrite;
    logic                    Mem_MemRead;
    logic [31:0]             Mem_ReadData;

    modport slave (
        input  Req, Write, Lock, Addr, WData, Mem_ReadData,
        output Grant, RdValid, RdData, LockErr,
               Mem_Address, Mem_WriteData, Mem_MemWrite, Mem_MemRead
    );

    modport master (
        output Req, Write, Lock, Addr, WData, Mem_ReadData,
        input  Grant, RdValid, RdData, LockErr,
               Mem_Address, Mem_WriteData, Mem_MemWrite, Mem_MemRead
    );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_CORES MEM stages.
// One registered command per cycle; load data returns tagged to the winner a cycle later.
// A core may hold a lock for back-to-back grants, bounded by LOCK_TIMEOUT consecutive grants.
module dmem_rr_arbiter #(
    parameter int NUM_CORES    = 4,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    dmem_rr_arbiter_if.slave bus
);
    localparam int         PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;
    localparam logic [7:0] TIMEOUT = 8'(LOCK_TIMEOUT);

    logic [0:0]           state_q,   state_d;
    logic [PTR_W-1:0]     ptr_q,     ptr_d;
    logic [PTR_W-1:0]     owner_q,   owner_d;
    logic [7:0]           timer_q,   timer_d;
    logic [NUM_CORES-1:0] mask_q,    mask_d;
    logic [NUM_CORES-1:0] grant_q,   grant_d;
    logic [NUM_CORES-1:0] rdvalid_q, rdvalid_d;
    logic [31:0]          rddata_q,  rddata_d;
    logic                 lockerr_q, lockerr_d;
    logic [31:0]          addr_q,    addr_d;
    logic [31:0]          wdata_q,   wdata_d;
    logic                 mwrite_q,  mwrite_d;
    logic                 mread_q,   mread_d;

    logic [NUM_CORES-1:0] eligible;
    logic                 found;
    logic [PTR_W-1:0]     win;
    logic                 gnt;
    logic [PTR_W-1:0]     gidx;

    // First eligible requester at or after the pointer, wrapping past the last core
    always_comb begin
        int idx;
        idx      = 0;
        eligible = bus.Req & ~mask_q;
        found    = 1'b0;
        win      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!found && eligible[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    // Arbitration / lock sequencing plus the next memory command and read return
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timer_d   = timer_q;
        lockerr_d = 1'b0;
        grant_d   = '0;
        mask_d    = '0;
        gnt       = 1'b0;
        gidx      = win;
        case (state_q)
            ST_ARB: begin
                if (found) begin
                    gnt   = 1'b1;
                    gidx  = win;
                    ptr_d = (win == PTR_W'(NUM_CORES - 1)) ? '0 : win + PTR_W'(1);
                    if (bus.Lock[win]) begin
                        state_d = ST_LOCK;
                        owner_d = win;
                        timer_d = 8'd1;
                    end
                end
            end
            default: begin
                if (timer_q == TIMEOUT) begin
                    // forced release: owner sits out the next arbitration edge
                    lockerr_d       = 1'b1;
                    state_d         = ST_ARB;
                    timer_d         = 8'd0;
                    mask_d[owner_q] = 1'b1;
                end else if (bus.Req[owner_q]) begin
                    gnt  = 1'b1;
                    gidx = owner_q;
                    if (bus.Lock[owner_q]) begin
                        timer_d = timer_q + 8'd1;
                    end else begin
                        state_d = ST_ARB;
                        timer_d = 8'd0;
                    end
                end else begin
                    state_d = ST_ARB;
                    timer_d = 8'd0;
                end
            end
        endcase
        if (gnt) grant_d[gidx] = 1'b1;
        mask_d = mask_d | grant_d;

        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mwrite_d = 1'b0;
        mread_d  = 1'b0;
        if (gnt) begin
            addr_d   = bus.Addr[32*gidx +: 32];
            mwrite_d = bus.Write[gidx];
            mread_d  = ~bus.Write[gidx];
            wdata_d  = bus.Write[gidx] ? bus.WData[32*gidx +: 32] : 32'd0;
        end

        rdvalid_d = mread_q ? grant_q : '0;
        rddata_d  = mread_q ? bus.Mem_ReadData : rddata_q;
    end

    // State, command and read-return registers; reset also drops any in-flight load
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            timer_q   <= 8'd0;
            mask_q    <= '0;
            grant_q   <= '0;
            rdvalid_q <= '0;
            rddata_q  <= 32'd0;
            lockerr_q <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            mwrite_q  <= 1'b0;
            mread_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            timer_q   <= timer_d;
            mask_q    <= mask_d;
            grant_q   <= grant_d;
            rdvalid_q <= rdvalid_d;
            rddata_q  <= rddata_d;
            lockerr_q <= lockerr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mwrite_q  <= mwrite_d;
            mread_q   <= mread_d;
        end
    end

    assign bus.Grant         = grant_q;
    assign bus.RdValid       = rdvalid_q;
    assign bus.RdData        = rddata_q;
    assign bus.LockErr       = lockerr_q;
    assign bus.Mem_Address   = addr_q;
    assign bus.Mem_WriteData = wdata_q;
    assign bus.Mem_MemWrite  = mwrite_q;
    assign bus.Mem_MemRead   = mread_q;
endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a rule-level reference model of the arbiter.
module tb_dmem_rr_arbiter;
    localparam int N  = 4;
    localparam int TO = 4;

    logic Clk;
    logic Reset;
    logic mem_clear;

    dmem_rr_arbiter_if #(.NUM_CORES(N)) bus ();

    dmem_rr_arbiter #(.NUM_CORES(N), .LOCK_TIMEOUT(TO)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'hDEADBEEF : ((32'(i) * 32'h01030507) ^ 32'h5A5A0000);
    endfunction

    // Data memory seen by the DUT: asynchronous read, write on posedge
    logic [31:0] tb_mem [64];
    always @(posedge Clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_val(i);
        end else if (bus.Mem_MemWrite) begin
            tb_mem[bus.Mem_Address[7:2]] <= bus.Mem_WriteData;
        end
    end
    assign bus.Mem_ReadData = tb_mem[bus.Mem_Address[7:2]];

    int checks;
    int errors;

    // Reference model: ints/indices, -1 meaning "none"
    logic [31:0] ref_mem [64];
    int          m_ptr, m_owner, m_cnt, m_masked, m_grant, m_rdvalid;
    logic        m_write, m_read, m_lockerr;
    logic [31:0] m_addr, m_wdata, m_rddata;
    bit          pend [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_cnt = 0; m_masked = -1; m_grant = -1; m_rdvalid = -1;
        m_write = 1'b0; m_read = 1'b0; m_lockerr = 1'b0;
        m_addr = 32'd0; m_wdata = 32'd0; m_rddata = 32'd0;
    endtask

    // Advance the model across one posedge using the inputs currently driven
    task automatic model_step();
        int w;
        int old_owner;
        bit to;
        w = -1; to = 1'b0; old_owner = m_owner;
        m_rdvalid = -1;
        if (m_grant >= 0 && m_read) begin
            m_rdvalid = m_grant;
            m_rddata  = ref_mem[m_addr[7:2]];
        end
        if (m_grant >= 0 && m_write) ref_mem[m_addr[7:2]] = m_wdata;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (w < 0 && bus.Req[c] && c != m_masked) w = c;
            end
            if (w >= 0) begin
                m_ptr = (w + 1) % N;
                if (bus.Lock[w]) begin m_owner = w; m_cnt = 1; end
            end
        end else if (m_cnt == TO) begin
            to = 1'b1; m_owner = -1; m_cnt = 0;
        end else if (bus.Req[m_owner]) begin
            w = m_owner;
            if (bus.Lock[m_owner]) m_cnt = m_cnt + 1;
            else begin m_owner = -1; m_cnt = 0; end
        end else begin
            m_owner = -1; m_cnt = 0;
        end
        m_lockerr = to;
        m_masked  = to ? old_owner : w;
        m_grant   = w;
        if (w >= 0) begin
            m_addr  = bus.Addr[32*w +: 32];
            m_write = bus.Write[w];
            m_read  = !bus.Write[w];
            m_wdata = bus.Write[w] ? bus.WData[32*w +: 32] : 32'd0;
        end else begin
            m_write = 1'b0;
            m_read  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("grant",    32'(bus.Grant),   (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0);
        chk("rdvalid",  32'(bus.RdValid), (m_rdvalid >= 0) ? (32'd1 << m_rdvalid) : 32'd0);
        chk("rddata",   bus.RdData, m_rddata);
        chk("lockerr",  32'(bus.LockErr), 32'(m_lockerr));
        chk("mem_addr", bus.Mem_Address, m_addr);
        chk("mem_wdat", bus.Mem_WriteData, m_wdata);
        chk("mem_we",   32'(bus.Mem_MemWrite), 32'(m_write));
        chk("mem_re",   32'(bus.Mem_MemRead), 32'(m_read));
        chk("rw_excl",  32'(bus.Mem_MemWrite & bus.Mem_MemRead), 32'd0);
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic set_cmd(input int c, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic lk);
        bus.Write[c]        = wr;
        bus.Addr[32*c +: 32]  = a;
        bus.WData[32*c +: 32] = d;
        bus.Lock[c]         = lk;
        bus.Req[c]          = 1'b1;
    endtask

    task automatic new_cmd(input int c);
        bus.Write[c]          = 1'($urandom_range(0, 1));
        bus.Addr[32*c +: 32]  = 32'($urandom_range(0, 63)) << 2;
        bus.WData[32*c +: 32] = $urandom;
        bus.Lock[c]           = ($urandom_range(0, 99) < 25);
    endtask

    initial begin
        int g;
        logic [3:0] exp_seq [8];
        checks = 0; errors = 0;
        Reset = 1'b0; mem_clear = 1'b1;
        bus.Req = '0; bus.Write = '0; bus.Lock = '0; bus.Addr = '0; bus.WData = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        for (int c = 0; c < N; c++) pend[c] = 1'b0;
        model_reset();
        @(negedge Clk); @(negedge Clk);
        mem_clear = 1'b0;
        check_outputs();
        chk("reset_grant", 32'(bus.Grant), 32'd0);
        Reset = 1'b1;
        tick();

        // single core load, held: grant on alternate cycles, data the cycle after
        set_cmd(2, 1'b0, 32'h40, 32'h0, 1'b0);
        tick(); chk("t2_grant1", 32'(bus.Grant), 32'd4); chk("t2_re", 32'(bus.Mem_MemRead), 32'd1);
                chk("t2_addr", bus.Mem_Address, 32'h40);
        tick(); chk("t2_gap", 32'(bus.Grant), 32'd0); chk("t2_rdv", 32'(bus.RdValid), 32'd4);
                chk("t2_data", bus.RdData, 32'hDEADBEEF);
        tick(); chk("t2_grant2", 32'(bus.Grant), 32'd4);
        tick(); chk("t2_rdv2", 32'(bus.RdValid), 32'd4);
        bus.Req = '0;
        tick();

        // asynchronous reset in the middle of a load grant
        set_cmd(0, 1'b0, 32'h8, 32'h0, 1'b0);
        tick(); chk("t1_grant", 32'(bus.Grant), 32'd1);
        bus.Req = '0;
        #1 Reset = 1'b0;
        #1;
        chk("t1_grant0", 32'(bus.Grant), 32'd0);
        chk("t1_re0", 32'(bus.Mem_MemRead), 32'd0);
        chk("t1_addr0", bus.Mem_Address, 32'd0);
        chk("t1_data0", bus.RdData, 32'd0);
        model_reset();
        @(negedge Clk);
        check_outputs();
        Reset = 1'b1;
        tick(); chk("t1_no_rdv", 32'(bus.RdValid), 32'd0);

        // all four request: strict rotation from core 0, no idle cycles
        for (int c = 0; c < N; c++) set_cmd(c, 1'b0, 32'(c * 4), 32'h0, 1'b0);
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            tick(); chk("t3_seq", 32'(bus.Grant), 32'(exp_seq[i]));
        end
        bus.Req = '0;
        tick();

        // store by core 1, then core 0 reads it back
        set_cmd(1, 1'b1, 32'h10, 32'h12345678, 1'b0);
        tick(); chk("t4_grant", 32'(bus.Grant), 32'd2); chk("t4_we", 32'(bus.Mem_MemWrite), 32'd1);
                chk("t4_re", 32'(bus.Mem_MemRead), 32'd0); chk("t4_wd", bus.Mem_WriteData, 32'h12345678);
        bus.Req = '0;
        tick(); chk("t4_no_rdv", 32'(bus.RdValid), 32'd0);
        set_cmd(0, 1'b0, 32'h10, 32'h0, 1'b0);
        tick(); chk("t4_ld_grant", 32'(bus.Grant), 32'd1);
        bus.Req = '0;
        tick(); chk("t4_rdv", 32'(bus.RdValid), 32'd1); chk("t4_data", bus.RdData, 32'h12345678);

        // lock by core 3 while core 0 waits
        set_cmd(0, 1'b0, 32'h20, 32'h0, 1'b0);
        set_cmd(3, 1'b0, 32'h24, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t5_lock", 32'(bus.Grant), 32'd8);
        end
        bus.Lock[3] = 1'b0;
        tick(); chk("t5_final", 32'(bus.Grant), 32'd8); chk("t5_noerr", 32'(bus.LockErr), 32'd0);
        bus.Req[3] = 1'b0;
        tick(); chk("t5_core0", 32'(bus.Grant), 32'd1);
        bus.Req = '0;
        tick();

        // lock held past the timeout by core 1, core 2 waiting
        set_cmd(1, 1'b0, 32'h30, 32'h0, 1'b1);
        set_cmd(2, 1'b1, 32'h34, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < TO; i++) begin
            tick(); chk("t6_lock", 32'(bus.Grant), 32'd2);
        end
        tick(); chk("t6_stop", 32'(bus.Grant), 32'd0); chk("t6_err", 32'(bus.LockErr), 32'd1);
        tick(); chk("t6_other", 32'(bus.Grant), 32'd4); chk("t6_err_off", 32'(bus.LockErr), 32'd0);
        bus.Req = '0; bus.Lock = '0;
        tick(); tick();

        // randomized traffic; requests held until granted, locked winners often continue
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom_range(0, 99) < 35) begin
                    pend[c] = 1'b1;
                    new_cmd(c);
                end
                bus.Req[c] = pend[c];
            end
            tick();
            if (m_grant >= 0) begin
                g = m_grant;
                if (bus.Lock[g] && $urandom_range(0, 99) < 75) new_cmd(g);
                else pend[g] = 1'b0;
            end
        end
        bus.Req = '0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
